// File: rtl/ccff_chain_loader.sv
// Configuration flip-flop chain loader: streams config words LSB first into one tile's ccff chain.
// Optional build macro CCFF_VERIFY_EN prepends a marker and checks it arrives at ccff_tail.
module ccff_chain_loader #(
  parameter int unsigned          CHAIN_LEN = 1024,
  parameter int unsigned          WORD_W    = 32,
  parameter int unsigned          MARKER_W  = 8,
  parameter logic [MARKER_W-1:0]  MARKER    = 8'hA5,
  localparam int unsigned         CNT_W     = $clog2(CHAIN_LEN + MARKER_W + 1)
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  bit_count
);

`ifdef CCFF_VERIFY_EN
  localparam int unsigned TOTAL_I = CHAIN_LEN + MARKER_W;
`else
  localparam int unsigned TOTAL_I = CHAIN_LEN;
`endif
  localparam int unsigned REQ_W = $clog2(CHAIN_LEN + 1);
  localparam int unsigned BC_W  = $clog2(WORD_W + 1);
  localparam int unsigned MK_W  = (MARKER_W > 1) ? $clog2(MARKER_W) : 1;
  localparam logic [CNT_W-1:0] TOTAL    = CNT_W'(TOTAL_I);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [BC_W-1:0]  BC_ONE   = BC_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
`ifdef CCFF_VERIFY_EN
    ST_MARK,
`endif
    ST_LOAD,
    ST_STALL,
    ST_DONE
  } state_t;

  state_t              state, state_nxt;
  logic [WORD_W-1:0]   buf_q, buf_nxt;
  logic [BC_W-1:0]     bcnt, bcnt_nxt;
  logic [REQ_W-1:0]    req, req_nxt;
  logic [BC_W-1:0]     take;
  logic [CNT_W-1:0]    cnt_nxt;
  logic                head_nxt, shift_nxt, done_nxt, err_nxt;
  logic                consume, accept;

  assign busy    = (state == ST_LOAD) || (state == ST_STALL)
`ifdef CCFF_VERIFY_EN
                   || (state == ST_MARK)
`endif
                   ;
  assign consume   = (state == ST_LOAD) && (bit_count != TOTAL) && (bcnt != '0);
  // Ready early when the last buffered bit leaves this cycle so valid-held streams never bubble.
  assign cfg_ready = busy && (req != '0) && ((bcnt == '0) || ((bcnt == BC_ONE) && consume));
  assign accept    = cfg_valid && cfg_ready;

  always_comb begin
    if (32'(req) >= WORD_W) take = BC_W'(WORD_W);
    else                    take = BC_W'(req);
  end

`ifndef CCFF_VERIFY_EN
  logic unused_cfg;
  assign unused_cfg = ccff_tail ^ (^MARKER);
`endif

  always_comb begin
    state_nxt = state;
    head_nxt  = ccff_head;
    shift_nxt = 1'b0;
    cnt_nxt   = bit_count;
    done_nxt  = done;
    err_nxt   = error;
    buf_nxt   = buf_q;
    bcnt_nxt  = bcnt;
    req_nxt   = req;

    if (consume) begin
      buf_nxt  = buf_q >> 1;
      bcnt_nxt = bcnt - BC_ONE;
    end
    if (accept) begin
      buf_nxt  = cfg_data;
      bcnt_nxt = take;
      req_nxt  = req - REQ_W'(take);
    end

`ifdef CCFF_VERIFY_EN
    // bit_count already counts the bit shifting now, so shift k has bit_count == k+1.
    if (ccff_shift_en && (bit_count > CNT_W'(CHAIN_LEN)) &&
        (ccff_tail != MARKER[MK_W'(bit_count - CNT_W'(CHAIN_LEN + 1))]))
      err_nxt = 1'b1;
`endif

    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          cnt_nxt  = '0;
          done_nxt = 1'b0;
          err_nxt  = 1'b0;
          req_nxt  = REQ_W'(CHAIN_LEN);
`ifdef CCFF_VERIFY_EN
          state_nxt = ST_MARK;
`else
          state_nxt = ST_LOAD;
`endif
        end
      end
`ifdef CCFF_VERIFY_EN
      ST_MARK: begin
        head_nxt  = MARKER[MK_W'(bit_count)];
        shift_nxt = 1'b1;
        cnt_nxt   = bit_count + CNT_ONE;
        if (bit_count == CNT_W'(MARKER_W - 1)) state_nxt = ST_LOAD;
      end
`endif
      ST_LOAD: begin
        if (bit_count == TOTAL) begin
          done_nxt  = 1'b1;
          state_nxt = ST_DONE;
        end else if (bcnt != '0) begin
          head_nxt  = buf_q[0];
          shift_nxt = 1'b1;
          cnt_nxt   = bit_count + CNT_ONE;
        end else if (!accept) begin
          state_nxt = ST_STALL;
        end
      end
      ST_STALL: begin
        if (accept) state_nxt = ST_LOAD;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      state         <= ST_IDLE;
      ccff_head     <= 1'b0;
      ccff_shift_en <= 1'b0;
      bit_count     <= '0;
      done          <= 1'b0;
      error         <= 1'b0;
      buf_q         <= '0;
      bcnt          <= '0;
      req           <= '0;
    end else begin
      state         <= state_nxt;
      ccff_head     <= head_nxt;
      ccff_shift_en <= shift_nxt;
      bit_count     <= cnt_nxt;
      done          <= done_nxt;
      error         <= err_nxt;
      buf_q         <= buf_nxt;
      bcnt          <= bcnt_nxt;
      req           <= req_nxt;
    end
  end

endmodule
